// File: rtl/seq_mult_shift_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mult_shift_add (with helper rca_adder)                    |
// | Purpose  : Sequential unsigned N x N shift-and-add multiplier producing  |
// |            a 2N-bit product after N iterations, one add per cycle        |
// |            through an N-bit ripple-carry adder.                          |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            start           - begin a multiply (sampled only when idle)   |
// |            a, b            - N-bit unsigned multiplicand / multiplier    |
// |            busy            - high while iterating                        |
// |            done            - one-cycle pulse, product final              |
// |            product         - 2N-bit product register                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

// N-bit ripple-carry adder: {carry, sum} = a + b + cin.
module rca_adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry
);

  logic [N:0] c;

  assign c[0]  = cin;
  assign carry = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

endmodule

module seq_mult_shift_add #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int              CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     m_q,     m_d;
  logic [2*N-1:0]   p_q,     p_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;

  // Add stage: accumulator (upper half of P) plus M gated by the current
  // multiplier LSB.
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N-1:0] add_sum;
  logic         add_carry;

  assign add_a = p_q[2*N-1:N];
  assign add_b = p_q[0] ? m_q : '0;

  rca_adder #(
    .N (N)
  ) u_adder (
    .a     (add_a),
    .b     (add_b),
    .cin   (1'b0),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {{N{1'b0}}, b};
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Carry-out lands in the MSB so no overflow bit is ever lost.
        p_d   = {add_carry, add_sum, p_q[N-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: busy is registered from the upcoming state so it is a clean
  // flop output aligned with CALC; done decodes the current state.
  always_comb begin
    busy_d  = (state_d == ST_CALC);
    busy    = busy_q;
    done    = (state_q == ST_DONE);
    product = p_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_shift_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mult_shift_add                                         |
// | Purpose  : Directed self-checking bench for seq_mult_shift_add (N=5).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_mult_shift_add;

  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_vec;
  int n_err;

  seq_mult_shift_add #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply and reports what was observed; checks live in callers.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        output logic [2*N-1:0] done_prod,
                        output logic [2*N-1:0] idle_prod,
                        output int lat, output int busy_cnt,
                        output int done_cnt, output int overlap);
    done_prod = '0;
    lat = -1; busy_cnt = 0; done_cnt = 0; overlap = 0;
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    a = N'($urandom); b = N'($urandom);
    for (int k = 0; k < N + 6; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        lat = k;
        done_prod = product;
      end
      if (busy === 1'b1 && done === 1'b1) overlap++;
      tick();
    end
    idle_prod = product;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({product, busy, done} !== {10'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d: product=%0d busy=%b done=%b, want 0/0/0",
                 k, product, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    run_op(5'd13, 5'd6, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd78) begin n_err++; $display("FAIL basic_prod: got %0d want 78", dp); end
    n_vec++; if (ip !== 10'd78) begin n_err++; $display("FAIL basic_idle_prod: got %0d want 78", ip); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", lat); end
    n_vec++; if (bc !== 5) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 5", bc); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
    n_vec++; if (ov !== 0) begin n_err++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ov); end
  endtask

  task automatic test_carry();
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    run_op(5'd31, 5'd31, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd961) begin n_err++; $display("FAIL carry_31x31: got %0d want 961", dp); end
    n_vec++; if (ip !== 10'd961) begin n_err++; $display("FAIL carry_31x31_idle: got %0d want 961", ip); end
    run_op(5'd31, 5'd1, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd31) begin n_err++; $display("FAIL carry_31x1: got %0d want 31", dp); end
    run_op(5'd1, 5'd31, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd31) begin n_err++; $display("FAIL carry_1x31: got %0d want 31", dp); end
  endtask

  task automatic test_zero();
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    run_op(5'd0, 5'd27, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd0) begin n_err++; $display("FAIL zero_0x27: got %0d want 0", dp); end
    n_vec++; if (lat !== 5 || bc !== 5 || dc !== 1) begin
      n_err++; $display("FAIL zero_0x27_timing: lat=%0d busy=%0d done=%0d want 5/5/1", lat, bc, dc);
    end
    run_op(5'd19, 5'd0, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd0) begin n_err++; $display("FAIL zero_19x0: got %0d want 0", dp); end
    n_vec++; if (lat !== 5 || bc !== 5 || dc !== 1) begin
      n_err++; $display("FAIL zero_19x0_timing: lat=%0d busy=%0d done=%0d want 5/5/1", lat, bc, dc);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    dones = 0;
    a = 5'd9; b = 5'd7; start = 1'b1;
    tick();                               // accepted; CALC cycle 1
    start = 1'b0;
    for (int c = 2; c <= N; c++) begin
      tick();                             // now in CALC cycle c
      if (done === 1'b1) dones++;
      start = (c == 2 || c == 4);
      a = 5'd3; b = 5'd3;
    end
    start = 1'b0;
    tick();                               // done cycle
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL swb_done: got %b want 1", done); end
    n_vec++; if (product !== 10'd63) begin n_err++; $display("FAIL swb_prod: got %0d want 63", product); end
    if (done === 1'b1) dones++;
    start = 1'b1;                         // start during the done cycle
    tick();
    start = 1'b0;
    n_vec++; if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL swb_ignored_in_done: busy=%b done=%b want 0/0", busy, done);
    end
    n_vec++; if (product !== 10'd63) begin n_err++; $display("FAIL swb_idle_prod: got %0d want 63", product); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL swb_done_pulses: got %0d want 1", dones); end
    run_op(5'd3, 5'd3, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd9) begin n_err++; $display("FAIL swb_next_op: got %0d want 9", dp); end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    // Start one cycle after done: done cycle then immediate start in IDLE.
    a = 5'd9; b = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) tick();   // now in the done cycle
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
    tick();                               // IDLE
    run_op(5'd3, 5'd3, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd9 || lat !== 5) begin
      n_err++; $display("FAIL b2b_prod: got %0d lat=%0d want 9 lat=5", dp, lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [2*N-1:0] dp, ip;
    int lat, bc, dc, ov;
    dones = 0;
    a = 5'd21; b = 5'd11; start = 1'b1;
    tick();                               // CALC cycle 1
    start = 1'b0;
    tick();                               // CALC cycle 2
    tick();                               // CALC cycle 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if ({product, busy, done} !== {10'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rstmid_state: product=%0d busy=%b done=%b want 0/0/0", product, busy, done);
    end
    for (int k = 0; k < N + 3; k++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", dones); end
    run_op(5'd21, 5'd11, dp, ip, lat, bc, dc, ov);
    n_vec++; if (dp !== 10'd231) begin n_err++; $display("FAIL rstmid_rerun: got %0d want 231", dp); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
